spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_slave_rx_if.sv | 15 +
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_slave_rx.sv | 154 +++++++++++++++
 tb/tb_spi_slave_rx.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg -- definitions shared by spi_slave_rx and spi_control_unit.
//   spi_state_e     : frame-level FSM state (IDLE / ACTIVE)
//   SPI_DATA_WIDTH  : default number of bits per SPI byte
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if -- the four SPI pins between a bus master and spi_slave_rx.
//   sclk : serial clock (idle low, mode 0)
//   cs   : chip select, active low
//   mosi : master-to-slave data
//   miso : slave-to-master data
// modport master drives sclk/cs/mosi and reads miso; modport slave is the mirror.
interface spi_slave_rx_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs, output mosi, input miso);
    modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge -- multi-flop synchronizer for one asynchronous input plus
// single-cycle rise/fall pulses derived from the last two synchronized samples.
//   clk      : system clock
//   reset    : synchronous, active-low; chain loads RESET_VAL
//   async_i  : asynchronous input
//   rise_o   : one-clk pulse, synchronized 0->1
//   fall_o   : one-clk pulse, synchronized 1->0
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    // Fewer than two flops gives no metastability protection; clamp.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;
    logic         prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {N{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[N-2:0], async_i};
            prev_q <= sync_q[N-1];
        end
    end

    assign rise_o =  sync_q[N-1] & ~prev_q;
    assign fall_o = ~sync_q[N-1] &  prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx -- SPI mode 0, MSB-first slave receiver with a return channel.
//   clk, reset        : system clock, synchronous active-low reset
//   spi (slave)       : sclk/cs/mosi inputs (asynchronous), miso output
//   tx_data           : byte returned on miso during the next byte slot
//   data_out          : last complete received byte (held until the next)
//   data_valid        : one-clk pulse, data_out holds a new byte
//   frame_start/end   : one-clk pulses on synchronized cs fall/rise
//   frame_abort       : one-clk pulse when cs rises with a partial byte
//   dbg_state_o       : current FSM state for observation
//
// Output handshake: data_valid is a single-cycle strobe with no ready/backpressure;
// the consumer must capture data_out in the cycle data_valid is high (data_out
// stays stable afterwards until the next strobe anyway).
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_slave_rx_if.slave         spi,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  frame_abort,
    output spi_state_e            dbg_state_o
);

    localparam int N     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(N), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (spi.sclk),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(N), .RESET_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (spi.cs),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // mosi uses the same depth as sclk so a sampled bit lines up with the
    // sclk edge that was detected in the same cycle.
    logic [N-1:0]            mosi_sync_q;
    spi_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   rx_shift_q;
    logic [DATA_WIDTH-1:0]   tx_shift_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    data_valid_q;
    logic                    frame_start_q;
    logic                    frame_end_q;
    logic                    frame_abort_q;
    logic                    miso_q;

    logic [DATA_WIDTH-1:0]   rx_next;
    logic                    last_bit;
    logic                    partial_after;

    assign rx_next  = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q[N-1]};
    assign last_bit = (cnt_q == LAST_BIT);
    // Is a byte left unfinished once this cycle's sclk rise (if any) is counted?
    // A rise completing the last bit closes the byte, so cs may rise with it.
    assign partial_after = sclk_rise ? !last_bit : (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            mosi_sync_q   <= '0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_abort_q <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            mosi_sync_q   <= {mosi_sync_q[N-2:0], spi.mosi};
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_abort_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        state_q       <= ACTIVE;
                        cnt_q         <= '0;
                        rx_shift_q    <= '0;
                        // MSB goes out now; the shift register keeps the rest.
                        miso_q        <= tx_data[DATA_WIDTH-1];
                        tx_shift_q    <= tx_data << 1;
                        frame_start_q <= 1'b1;
                    end
                end

                ACTIVE: begin
                    if (sclk_rise) begin
                        rx_shift_q <= rx_next;
                        if (last_bit) begin
                            cnt_q        <= '0;
                            data_out_q   <= rx_next;
                            data_valid_q <= 1'b1;
                            // Full reload: the next falling edge emits its MSB.
                            tx_shift_q   <= tx_data;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        miso_q     <= tx_shift_q[DATA_WIDTH-1];
                        tx_shift_q <= tx_shift_q << 1;
                    end

                    // Placed last so it overrides the shift updates above.
                    if (cs_rise) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        rx_shift_q    <= '0;
                        tx_shift_q    <= '0;
                        miso_q        <= 1'b0;
                        frame_end_q   <= 1'b1;
                        frame_abort_q <= partial_after;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi.miso    = miso_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_abort = frame_abort_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx -- self-checking bench for spi_slave_rx.
// The SPI master runs sclk at clk/8; the reference model is a byte-level view:
// each fully shifted byte is expected once on data_out, a trailing partial
// byte is expected to raise frame_abort, and miso returns tx_data per slot.
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int W    = 8;
    localparam int HALF = 4;   // clk cycles per sclk half period

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] tx_data;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         frame_start;
    logic         frame_end;
    logic         frame_abort;
    spi_state_e   dbg_state;

    spi_slave_rx_if spi_if ();

    spi_slave_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi         (spi_if),
        .tx_data     (tx_data),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .frame_abort (frame_abort),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    int           dv_cnt = 0, fs_cnt = 0, fe_cnt = 0, ab_cnt = 0, ab_alone_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mo_q[$];
    logic [W-1:0] exp_last = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: every data_valid is compared against the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (data_valid) begin
                dv_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL dv_unexpected: got data_valid with data 0x%0h, expected no byte", data_out);
                end else begin
                    check("scoreboard_byte", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
            if (frame_start) fs_cnt++;
            if (frame_end)   fe_cnt++;
            if (frame_abort) ab_cnt++;
            if (frame_abort && !frame_end) ab_alone_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift the top nbits of v, MSB first; capture miso on each sclk rise.
    task automatic spi_bits(input logic [W-1:0] v, input int nbits, output logic [W-1:0] mi);
        mi = '0;
        for (int i = W - 1; i >= W - nbits; i--) begin
            spi_if.mosi = v[i];
            wait_clk(HALF);
            spi_if.sclk = 1'b1;
            mi[i] = spi_if.miso;
            wait_clk(HALF);
            spi_if.sclk = 1'b0;
        end
    endtask

    // One cs-framed transfer of mo_q, optionally followed by a partial byte.
    task automatic do_frame(input logic [W-1:0] tx, input int partial_n,
                            input logic [W-1:0] partial_v, output logic [W-1:0] last_mi);
        int fs0, fe0, ab0, dv0, nbytes;
        logic [W-1:0] mi;
        fs0 = fs_cnt; fe0 = fe_cnt; ab0 = ab_cnt; dv0 = dv_cnt;
        nbytes  = mo_q.size();
        last_mi = '0;
        tx_data = tx;
        spi_if.cs = 1'b0;
        wait_clk(HALF);
        foreach (mo_q[k]) begin
            exp_q.push_back(mo_q[k]);
            spi_bits(mo_q[k], W, mi);
            check("miso_slot", 32'(mi), 32'(tx));
            last_mi  = mi;
            exp_last = mo_q[k];
        end
        if (partial_n > 0) spi_bits(partial_v, partial_n, mi);
        wait_clk(HALF);
        spi_if.cs = 1'b1;
        wait_clk(12);
        check("frame_start_cnt", 32'(fs_cnt - fs0), 32'd1);
        check("frame_end_cnt",   32'(fe_cnt - fe0), 32'd1);
        check("frame_abort_cnt", 32'(ab_cnt - ab0), (partial_n > 0) ? 32'd1 : 32'd0);
        check("data_valid_cnt",  32'(dv_cnt - dv0), 32'(nbytes));
        check("data_out_hold",   32'(data_out), 32'(exp_last));
        check("exp_q_drained",   32'(exp_q.size()), 32'd0);
        check("miso_idle",       32'(spi_if.miso), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] mo;
        logic [W-1:0] tx;
        logic [W-1:0] exp_data;
        logic [W-1:0] exp_miso;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [W-1:0] mi;
        int fs0, dv0, ab0, nb, pn, bad;

        vecs[0] = '{mo: 8'hA5, tx: 8'h5A, exp_data: 8'hA5, exp_miso: 8'h5A};
        vecs[1] = '{mo: 8'h00, tx: 8'hFF, exp_data: 8'h00, exp_miso: 8'hFF};
        vecs[2] = '{mo: 8'hFF, tx: 8'h00, exp_data: 8'hFF, exp_miso: 8'h00};
        vecs[3] = '{mo: 8'h3C, tx: 8'hC3, exp_data: 8'h3C, exp_miso: 8'hC3};
        vecs[4] = '{mo: 8'h80, tx: 8'h01, exp_data: 8'h80, exp_miso: 8'h01};
        vecs[5] = '{mo: 8'h01, tx: 8'h80, exp_data: 8'h01, exp_miso: 8'h80};

        // ---- reset ----
        reset = 1'b0;
        spi_if.cs = 1'b1; spi_if.sclk = 1'b0; spi_if.mosi = 1'b0;
        tx_data = '0;
        wait_clk(5);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_pulses",   32'({data_valid, frame_start, frame_end, frame_abort}), 32'd0);
        check("rst_miso",     32'(spi_if.miso), 32'd0);
        check("rst_state",    32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        wait_clk(5);

        // ---- table-driven single-byte frames ----
        for (int i = 0; i < 6; i++) begin
            mo_q.delete();
            mo_q.push_back(vecs[i].mo);
            do_frame(vecs[i].tx, 0, '0, mi);
            check("vec_data", 32'(data_out), 32'(vecs[i].exp_data));
            check("vec_miso", 32'(mi), 32'(vecs[i].exp_miso));
        end

        // ---- four back-to-back bytes in one frame ----
        mo_q.delete();
        mo_q.push_back(8'h01); mo_q.push_back(8'h05);
        mo_q.push_back(8'h07); mo_q.push_back(8'h09);
        do_frame(8'h3C, 0, '0, mi);
        check("b2b_last", 32'(data_out), 32'h09);

        // ---- abort after 5 bits of 0xFF following 0x12 ----
        mo_q.delete();
        mo_q.push_back(8'h12);
        do_frame(8'h00, 5, 8'hFF, mi);
        check("abort_hold", 32'(data_out), 32'h12);

        // ---- reset mid-byte after 3 bits ----
        dv0 = dv_cnt; ab0 = ab_cnt;
        tx_data = 8'h99;
        spi_if.cs = 1'b0;
        wait_clk(HALF);
        spi_bits(8'hE7, 3, mi);
        reset = 1'b0;
        spi_if.cs = 1'b1; spi_if.sclk = 1'b0; spi_if.mosi = 1'b0;
        wait_clk(3);
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_pulses",   32'({data_valid, frame_start, frame_end, frame_abort}), 32'd0);
        check("midrst_miso",     32'(spi_if.miso), 32'd0);
        check("midrst_state",    32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        exp_last = '0;
        wait_clk(12);
        check("midrst_no_dv",    32'(dv_cnt - dv0), 32'd0);
        check("midrst_no_abort", 32'(ab_cnt - ab0), 32'd0);
        mo_q.delete();
        mo_q.push_back(8'h81);
        do_frame(8'h42, 0, '0, mi);
        check("post_rst_byte", 32'(data_out), 32'h81);

        // ---- sclk toggling with cs high ----
        fs0 = fs_cnt; dv0 = dv_cnt; bad = 0;
        spi_if.cs = 1'b1;
        for (int e = 0; e < 16; e++) begin
            spi_if.sclk = ~spi_if.sclk;
            spi_if.mosi = 1'($urandom_range(0, 1));
            wait_clk(HALF);
            if (spi_if.miso !== 1'b0) bad++;
        end
        wait_clk(8);
        check("idle_miso_nonzero", 32'(bad), 32'd0);
        check("idle_no_dv",        32'(dv_cnt - dv0), 32'd0);
        check("idle_no_start",     32'(fs_cnt - fs0), 32'd0);
        check("idle_data_hold",    32'(data_out), 32'h81);

        // ---- cs rise coincident with the 8th sclk rise ----
        fs0 = fe_cnt; dv0 = dv_cnt; ab0 = ab_cnt;
        tx_data = 8'h00;
        spi_if.cs = 1'b0;
        wait_clk(HALF);
        exp_q.push_back(8'hC6);
        spi_bits(8'hC6, 7, mi);
        spi_if.mosi = 1'b0;              // bit 0 of 0xC6
        wait_clk(HALF);
        spi_if.sclk = 1'b1;
        spi_if.cs   = 1'b1;
        wait_clk(HALF);
        spi_if.sclk = 1'b0;
        wait_clk(12);
        exp_last = 8'hC6;
        check("corner_dv",    32'(dv_cnt - dv0), 32'd1);
        check("corner_end",   32'(fe_cnt - fs0), 32'd1);
        check("corner_abort", 32'(ab_cnt - ab0), 32'd0);
        check("corner_data",  32'(data_out), 32'hC6);

        // ---- randomized frames ----
        for (int f = 0; f < 10; f++) begin
            mo_q.delete();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) mo_q.push_back(W'($urandom_range(0, 255)));
            pn = ($urandom_range(0, 1) == 1) ? $urandom_range(1, W - 1) : 0;
            do_frame(W'($urandom_range(0, 255)), pn, W'($urandom_range(0, 255)), mi);
        end

        check("abort_without_end", 32'(ab_alone_cnt), 32'd0);
        check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
